// File: rtl/sdram_line_responder_pkg.sv
// rtl/sdram_line_responder_pkg.sv - shared types and constants for the SDRAM line responder
package sdram_resp_pkg;

    localparam int LINE_WORDS = 32;
    localparam int OFFSET_W   = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } resp_state_t;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        STRB_DROP = 3'd1,
        DIR_CHG   = 3'd2,
        ADDR_SEQ  = 3'd3,
        UNALIGNED = 3'd4
    } resp_err_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sdram_line_responder_if.sv
// rtl/sdram_line_responder_if.sv - cache-to-SDRAM beat bus with master/slave views
interface sdram_line_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              sdram_mstrb;
    logic              sdram_wr_rd;
    logic [ADDR_W-1:0] sdram_add;
    logic [DATA_W-1:0] sdram_din;
    logic [DATA_W-1:0] sdram_dout;

    modport master (output sdram_mstrb, sdram_wr_rd, sdram_add, sdram_din, input sdram_dout);
    modport slave  (input sdram_mstrb, sdram_wr_rd, sdram_add, sdram_din, output sdram_dout);
endinterface

// File: rtl/sdram_line_responder_mem.sv
// rtl/sdram_line_responder_mem.sv - word array, synchronous write, asynchronous read
module sdram_resp_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/sdram_line_responder.sv
// rtl/sdram_line_responder.sv - line-burst responder; protocol checker under SDRAM_RESP_CHECK_EN
module sdram_line_responder
    import sdram_resp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    sdram_line_if.slave bus,
    output logic        burst_active,
    output logic        line_done,
    output logic [15:0] wr_line_cnt,
`ifdef SDRAM_RESP_CHECK_EN
    output logic [15:0] rd_line_cnt,
    output logic        proto_err,
    output logic [2:0]  err_code
`else
    output logic [15:0] rd_line_cnt
`endif
);
    resp_state_t              state, state_d;
    logic [OFFSET_W-1:0]      beat, beat_d;
    logic [ADDR_W-OFFSET_W-1:0] base, base_d;
    logic                     done_d, wr_inc, rd_inc;
    resp_err_t                err_d;

    // Memory traffic is serviced on every strobe regardless of FSM state.
    sdram_resp_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (bus.sdram_mstrb & bus.sdram_wr_rd & rst_n),
        .addr  (bus.sdram_add),
        .wdata (bus.sdram_din),
        .rdata (bus.sdram_dout)
    );

    always_comb begin
        state_d = state;
        beat_d  = beat;
        base_d  = base;
        done_d  = 1'b0;
        wr_inc  = 1'b0;
        rd_inc  = 1'b0;
        err_d   = NONE;
        case (state)
            IDLE: begin
                if (bus.sdram_mstrb) begin
`ifdef SDRAM_RESP_CHECK_EN
                    if (bus.sdram_add[OFFSET_W-1:0] != '0) begin
                        err_d = UNALIGNED;
                    end else
`endif
                    begin
                        base_d  = bus.sdram_add[ADDR_W-1:OFFSET_W];
                        beat_d  = OFFSET_W'(1);
                        state_d = bus.sdram_wr_rd ? WR_BURST : RD_BURST;
                    end
                end
            end
            default: begin
                if (!bus.sdram_mstrb) err_d = STRB_DROP;
`ifdef SDRAM_RESP_CHECK_EN
                else if (bus.sdram_wr_rd != (state == WR_BURST)) err_d = DIR_CHG;
                else if (bus.sdram_add != {base, beat}) err_d = ADDR_SEQ;
`endif
                if (err_d != NONE) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat + OFFSET_W'(1);
                    if (beat == OFFSET_W'(LINE_WORDS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        wr_inc  = (state == WR_BURST);
                        rd_inc  = (state == RD_BURST);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            base        <= '0;
            line_done   <= 1'b0;
            wr_line_cnt <= '0;
            rd_line_cnt <= '0;
`ifdef SDRAM_RESP_CHECK_EN
            proto_err   <= 1'b0;
            err_code    <= 3'd0;
`endif
        end else begin
            state     <= state_d;
            beat      <= beat_d;
            base      <= base_d;
            line_done <= done_d;
            if (wr_inc) wr_line_cnt <= sat_inc(wr_line_cnt);
            if (rd_inc) rd_line_cnt <= sat_inc(rd_line_cnt);
`ifdef SDRAM_RESP_CHECK_EN
            // Only the first violation is recorded; later ones are ignored until reset.
            if (!proto_err && err_d != NONE) begin
                proto_err <= 1'b1;
                err_code  <= err_d;
            end
`endif
        end
    end

    assign burst_active = (state != IDLE);
endmodule
